system: RTL and testbench

SYSTEM -- requirements
Module: system

---
 rtl/system_pkg.sv | 32 +++
 rtl/system_seg7_scan.sv | 46 ++++
 rtl/system.sv | 140 ++++++++++++++
 tb/tb_system.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/system_pkg.sv
// Shared constants for the Fibonacci printer: parameter defaults, ASCII
// codes, the hex seven-segment font and the run-state encoding.
package system_pkg;

  localparam int NUM_TERMS_DEFAULT   = 24;
  localparam int BYTE_GAP_DEFAULT    = 16;
  localparam int REFRESH_DIV_DEFAULT = 1024;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  // Active-low {dp, g..a}; bit 7 stays high so the decimal point is dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    ST_RUN,    // streaming characters
    ST_FINAL,  // last newline just strobed
    ST_TRAP    // run complete, outputs frozen
  } run_state_e;

  // Uppercase hex digit as ASCII.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_ZERO + {4'h0, nib})
                         : (ASCII_UPPER_A + {4'h0, nib - 4'd10});
  endfunction

endpackage

// File: rtl/system_seg7_scan.sv
// Eight-digit multiplexed seven-segment driver. Digit 0 is the rightmost;
// a set bit in the blank mask darkens that digit.
module seg7_scan
  import system_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] i_digit_value,
  input  logic [7:0]  i_blank_mask,
  output logic [7:0]  anode_array,
  output logic [7:0]  cathode_array
);

  localparam int DIV_W = $clog2(REFRESH_DIV);

  // Low DIV_W bits pace the refresh, top three bits select the digit.
  logic [DIV_W+2:0] r_scan;
  logic [2:0]       w_digit;
  logic [3:0]       w_nibble;
  logic [7:0]       r_anode;
  logic [7:0]       r_cathode;

  assign w_digit  = r_scan[DIV_W+2:DIV_W];
  assign w_nibble = i_digit_value[{w_digit, 2'b00} +: 4];

  // Free-running scan counter and registered segment/anode drive.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (resetn) begin
      r_scan    <= '0;
      r_anode   <= 8'hFF;
      r_cathode <= SEG_BLANK;
    end else begin
      r_scan    <= r_scan + 1'b1;
      r_anode   <= ~(8'h01 << w_digit);
      r_cathode <= i_blank_mask[w_digit] ? SEG_BLANK : SEG_TABLE[w_nibble];
    end
  end

  assign anode_array   = r_anode;
  assign cathode_array = r_cathode;

endmodule

// File: rtl/system.sv
// Fibonacci term printer: streams each 32-bit term as eight hex characters
// plus newline, then raises trap. The latest term (or its index) is shown
// on an eight-digit seven-segment display selected by switch.
module system
  import system_pkg::*;
#(
  parameter int NUM_TERMS   = NUM_TERMS_DEFAULT,
  parameter int BYTE_GAP    = BYTE_GAP_DEFAULT,
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       switch,
  output logic       trap,
  output logic [7:0] out_byte,
  output logic       out_byte_en,
  output logic [7:0] cathode_array,
  output logic [7:0] anode_array
);

  localparam int               GAP_W    = $clog2(BYTE_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);
  localparam logic [7:0]       LAST_IDX = 8'(NUM_TERMS - 1);
  localparam logic [3:0]       CHAR_LF  = 4'd8;

  run_state_e       r_state, w_next_state;
  logic [GAP_W-1:0] r_gap;
  logic [3:0]       r_char;      // 0..7 hex digits, 8 newline
  logic [7:0]       r_index;
  logic [31:0]      r_fib_a;     // F(index)
  logic [31:0]      r_fib_b;     // F(index+1)
  logic [7:0]       r_out_byte;
  logic             r_out_en;
  logic [31:0]      r_disp_val;
  logic [7:0]       r_disp_idx;
  logic             r_sw_meta, r_sw_sync;

  logic             w_strobe;
  logic             w_last_byte;
  logic [2:0]       w_nib_sel;
  logic [3:0]       w_nibble;
  logic [7:0]       w_char_byte;
  logic [31:0]      w_scan_value;
  logic [7:0]       w_scan_blank;

  assign w_last_byte = (r_char == CHAR_LF) && (r_index == LAST_IDX);
  assign w_nib_sel   = 3'd7 - r_char[2:0];
  assign w_nibble    = r_fib_a[{w_nib_sel, 2'b00} +: 4];
  assign w_char_byte = (r_char == CHAR_LF) ? ASCII_LF : hex_to_ascii(w_nibble);

  // Run-state register.
  always_ff @(posedge clk) begin
    if (resetn) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Next state and strobe decision; trap follows one cycle after the last byte.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_strobe     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_strobe = (r_gap == GAP_LAST);
        if (w_strobe && w_last_byte) w_next_state = ST_FINAL;
      end
      ST_FINAL: w_next_state = ST_TRAP;
      ST_TRAP:  w_next_state = ST_TRAP;
      default:  w_next_state = ST_RUN;
    endcase
  end

  assign trap = (r_state == ST_TRAP);

  // Byte pacing, character sequencing and term advance on each newline.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_gap      <= '0;
      r_char     <= '0;
      r_index    <= '0;
      r_fib_a    <= 32'd0;
      r_fib_b    <= 32'd1;
      r_out_byte <= 8'h00;
      r_out_en   <= 1'b0;
      r_disp_val <= '0;
      r_disp_idx <= '0;
    end else begin
      r_gap    <= (r_gap == GAP_LAST) ? '0 : r_gap + 1'b1;
      r_out_en <= w_strobe;
      if (w_strobe) begin
        r_out_byte <= w_char_byte;
        if (r_char == '0) begin
          r_disp_val <= r_fib_a;
          r_disp_idx <= r_index;
        end
        if (r_char == CHAR_LF) begin
          r_char <= '0;
          // The final term stays in place so the frozen value is the last one printed.
          if (!w_last_byte) begin
            r_fib_a <= r_fib_b;
            r_fib_b <= r_fib_a + r_fib_b;
            r_index <= r_index + 1'b1;
          end
        end else begin
          r_char <= r_char + 1'b1;
        end
      end
    end
  end

  // Two-flop synchronizer for the asynchronous display select.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_sw_meta <= 1'b0;
      r_sw_sync <= 1'b0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_scan_value = r_sw_sync ? {24'h0, r_disp_idx} : r_disp_val;
  assign w_scan_blank = r_sw_sync ? 8'hFC : 8'h00;

  assign out_byte    = r_out_byte;
  assign out_byte_en = r_out_en;

  seg7_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk           (clk),
    .resetn        (resetn),
    .i_digit_value (w_scan_value),
    .i_blank_mask  (w_scan_blank),
    .anode_array   (anode_array),
    .cathode_array (cathode_array)
  );

endmodule

// File: tb/tb_system.sv
// Self-checking bench for system: scoreboard of expected ASCII bytes,
// strobe timing, trap behaviour, display contents and mid-stream reset.
module tb_system;

  localparam int NUM_TERMS     = 24;
  localparam int BYTE_GAP      = 16;
  localparam int REFRESH_DIV   = 1024;
  localparam int BYTES_PER_RUN = NUM_TERMS * 9;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       switch = 1'b0;
  logic       trap;
  logic [7:0] out_byte;
  logic       out_byte_en;
  logic [7:0] cathode_array;
  logic [7:0] anode_array;

  system dut (
    .clk           (clk),
    .resetn        (resetn),
    .switch        (switch),
    .trap          (trap),
    .out_byte      (out_byte),
    .out_byte_en   (out_byte_en),
    .cathode_array (cathode_array),
    .anode_array   (anode_array)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference font and model.
  logic [7:0]  font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] fib_model [NUM_TERMS];
  logic [7:0]  sb_q [$];

  function automatic logic [7:0] ascii_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    else           return 8'h37 + 8'(n);
  endfunction

  task automatic push_run();
    for (int t = 0; t < NUM_TERMS; t++) begin
      for (int k = 7; k >= 0; k--) sb_q.push_back(ascii_hex(fib_model[t][4*k +: 4]));
      sb_q.push_back(8'h0A);
    end
  endtask

  // Cycle count since reset release, settled by the next falling edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (resetn) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Output monitor: pops the scoreboard on every strobe.
  int         n_strobes = 0;
  int         last_cyc  = 0;
  bit         first_seen = 1'b0;
  bit         mon_en = 1'b0;
  bit         expect_trap = 1'b0;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    if (expect_trap) begin
      check("trap_after_last", trap, 1);
      expect_trap = 1'b0;
    end
    if (mon_en && !resetn) begin
      if (out_byte_en) begin
        n_strobes++;
        check("trap_low_while_streaming", trap, 0);
        if (!first_seen) check("first_strobe_cycle", cyc, BYTE_GAP);
        else             check("strobe_spacing", cyc - last_cyc, BYTE_GAP);
        first_seen = 1'b1;
        last_cyc   = cyc;
        last_byte  = out_byte;
        if (sb_q.size() == 0) begin
          check("unexpected_strobes", n_strobes, BYTES_PER_RUN);
        end else begin
          logic [7:0] exp_b;
          exp_b = sb_q.pop_front();
          check($sformatf("byte%0d", n_strobes - 1), out_byte, exp_b);
          if (sb_q.size() == 0) expect_trap = 1'b1;
        end
      end else if (first_seen) begin
        check("byte_hold", out_byte, last_byte);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_trap", tag), trap, 0);
    check($sformatf("%s_out_byte", tag), out_byte, 8'h00);
    check($sformatf("%s_out_byte_en", tag), out_byte_en, 0);
    check($sformatf("%s_anode", tag), anode_array, 8'hFF);
    check($sformatf("%s_cathode", tag), cathode_array, 8'hFF);
  endtask

  // Called on a falling edge: load a fresh expected stream and release reset.
  task automatic start_run();
    sb_q.delete();
    n_strobes  = 0;
    first_seen = 1'b0;
    push_run();
    mon_en = 1'b1;
    resetn = 1'b0;
  endtask

  task automatic wait_strobes(input int target);
    int k;
    k = 0;
    while (n_strobes < target && k < target * BYTE_GAP + 64) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("reach_strobe_%0d", target), 32'(n_strobes >= target), 1);
  endtask

  // Walk eight refresh slots, checking one-hot anode and the lit digit.
  task automatic scan_check(input string tag, input logic [7:0] exp [8]);
    logic [7:0] seen;
    logic [7:0] prev;
    int k;
    seen = '0;
    for (int s = 0; s < 8; s++) begin
      k = 0;
      prev = anode_array;
      while (anode_array == prev && k < REFRESH_DIV + 8) begin
        @(negedge clk);
        k++;
      end
      repeat (2) @(negedge clk);
      check($sformatf("%s_one_anode", tag), $countones(~anode_array), 1);
      for (int d = 0; d < 8; d++) begin
        if (!anode_array[d]) begin
          seen[d] = 1'b1;
          check($sformatf("%s_digit%0d", tag, d), cathode_array, exp[d]);
        end
      end
    end
    check($sformatf("%s_all_digits", tag), seen, 8'hFF);
  endtask

  logic [7:0] exp_val [8];
  logic [7:0] exp_idx [8];
  logic [7:0] last_idx;

  initial begin
    fib_model[0] = 32'd0;
    fib_model[1] = 32'd1;
    for (int i = 2; i < NUM_TERMS; i++) fib_model[i] = fib_model[i-1] + fib_model[i-2];
    last_idx = 8'(NUM_TERMS - 1);
    for (int d = 0; d < 8; d++) begin
      exp_val[d] = font[fib_model[NUM_TERMS-1][4*d +: 4]];
      exp_idx[d] = (d < 2) ? font[last_idx[4*d +: 4]] : 8'hFF;
    end

    // Power-on reset.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");

    // Full run; toggle the display select mid-stream, which must not matter.
    start_run();
    wait_strobes(20);
    switch = 1'b1;
    wait_strobes(40);
    switch = 1'b0;
    wait_strobes(BYTES_PER_RUN);
    repeat (3) @(negedge clk);
    check("trap_held", trap, 1);

    // Display of the final term, then of its index.
    switch = 1'b0;
    repeat (4) @(negedge clk);
    scan_check("disp_value", exp_val);
    check("no_strobes_after_trap", n_strobes, BYTES_PER_RUN);
    switch = 1'b1;
    repeat (4) @(negedge clk);
    scan_check("disp_index", exp_idx);
    check("trap_still_held", trap, 1);
    check("strobe_total_run1", n_strobes, BYTES_PER_RUN);

    // Reset pulse partway through a second run.
    switch = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    start_run();
    wait_strobes(50);
    resetn = 1'b1;
    mon_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("mid_reset");
    end
    start_run();
    wait_strobes(BYTES_PER_RUN);
    repeat (3) @(negedge clk);
    check("trap_after_restart", trap, 1);
    repeat (2 * BYTE_GAP) @(negedge clk);
    check("strobe_total_run2", n_strobes, BYTES_PER_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
